// File: rtl/mem_arbiter.sv
// Purpose: arbitrates the single-ported unified memory between fetch (if_*) and load/store (dm_*).
// Latency: aligned grant at T -> rvalid at T+MEM_LAT; misaligned grant at T -> rvalid (err) at T+1.
// Backpressure: one access in flight; requesters hold req until a one-cycle combinational gnt pulse.
//
// Ports:
//   clk, rst                  - clock (rising edge), asynchronous active-low reset
//   if_req/addr -> if_gnt     - fetch request and grant
//   if_rvalid/if_rdata        - fetch response
//   dm_req/wr/addr/wdata      - load/store request
//   dm_gnt                    - load/store grant
//   dm_rvalid/dm_rdata        - load data or store-complete response
//   err_p1                    - misaligned-access flag, qualified by if_rvalid or dm_rvalid
//   mem_en/wr/addr/wdata      - memory command, driven in the grant cycle
//   mem_rdata                 - memory read data, valid exactly MEM_LAT cycles after mem_en
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_p1,
    input  logic [ADDR_W-1:0] if_addr_p1,
    output logic              if_gnt_p1,
    output logic              if_rvalid_p1,
    output logic [DATA_W-1:0] if_rdata_p1,
    input  logic              dm_req_p1,
    input  logic              dm_wr_p1,
    input  logic [ADDR_W-1:0] dm_addr_p1,
    input  logic [DATA_W-1:0] dm_wdata_p1,
    output logic              dm_gnt_p1,
    output logic              dm_rvalid_p1,
    output logic [DATA_W-1:0] dm_rdata_p1,
    output logic              err_p1,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAT = CNT_W'(MEM_LAT);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_MAX);
    localparam logic [STV_W-1:0] STV_ONE = STV_W'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic [STV_W-1:0]  starve_cnt;
    logic              own_dm;   // 1: data port owns the in-flight access, 0: fetch
    logic              own_wr;   // in-flight access is a store
    logic              own_err;  // in-flight access was misaligned, never reached memory

    logic              resp_cyc;
    logic              gnt_ok;
    logic              starved;
    logic              if_wins;
    logic              gnt_if;
    logic              gnt_dm;
    logic              any_gnt;
    logic [ADDR_W-1:0] win_addr;
    logic              win_wr;
    logic              win_mis;

    // ------------------------------------------------------------------
    // Arbitration (combinational, shared by the FSM and the register file)
    // ------------------------------------------------------------------
    always_comb begin
        resp_cyc = (state == S_WAIT) && (cnt == CNT_ONE);
        // Gating with rst keeps grants low the instant reset asserts,
        // independent of how quickly the state register clears.
        gnt_ok   = rst && ((state == S_IDLE) || resp_cyc);
        starved  = (starve_cnt == STV_MAX);
        // Data has priority unless fetch has been passed over STARVE_MAX times.
        if_wins  = if_req_p1 && (!dm_req_p1 || starved);
        gnt_if   = gnt_ok && if_wins;
        gnt_dm   = gnt_ok && dm_req_p1 && !if_wins;
        any_gnt  = gnt_if || gnt_dm;
        win_addr = gnt_if ? if_addr_p1 : dm_addr_p1;
        win_wr   = gnt_dm && dm_wr_p1;
        win_mis  = any_gnt && win_addr[0];
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (any_gnt) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A grant in the response cycle chains straight into the next access.
                if (resp_cyc && !any_gnt) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        if_gnt_p1    = gnt_if;
        dm_gnt_p1    = gnt_dm;

        // Misaligned accesses are granted but never touch memory.
        mem_en       = any_gnt && !win_mis;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (mem_en) begin
            mem_wr    = win_wr;
            mem_addr  = win_addr;
            mem_wdata = win_wr ? dm_wdata_p1 : '0;
        end

        if_rvalid_p1 = 1'b0;
        if_rdata_p1  = '0;
        dm_rvalid_p1 = 1'b0;
        dm_rdata_p1  = '0;
        err_p1       = 1'b0;
        if (resp_cyc) begin
            err_p1 = own_err;
            if (own_dm) begin
                dm_rvalid_p1 = 1'b1;
                dm_rdata_p1  = (!own_wr && !own_err) ? mem_rdata : '0;
            end else begin
                if_rvalid_p1 = 1'b1;
                if_rdata_p1  = own_err ? '0 : mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Access bookkeeping: owner, kind, error flag and latency counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            own_dm  <= 1'b0;
            own_wr  <= 1'b0;
            own_err <= 1'b0;
        end else if (any_gnt) begin
            cnt     <= win_mis ? CNT_ONE : CNT_LAT;
            own_dm  <= gnt_dm;
            own_wr  <= win_wr;
            own_err <= win_mis;
        end else if (state == S_WAIT) begin
            // Reaches zero as the FSM drops back to IDLE after the response.
            cnt     <= cnt - CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Fetch starvation counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!if_req_p1 || gnt_if) begin
            starve_cnt <= '0;
        end else if (gnt_dm && !starved) begin
            starve_cnt <= starve_cnt + STV_ONE;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int MEM_LAT    = 4;
    localparam int STARVE_MAX = 3;

    logic              clk;
    logic              rst;
    logic              if_req_p1;
    logic [ADDR_W-1:0] if_addr_p1;
    logic              if_gnt_p1;
    logic              if_rvalid_p1;
    logic [DATA_W-1:0] if_rdata_p1;
    logic              dm_req_p1;
    logic              dm_wr_p1;
    logic [ADDR_W-1:0] dm_addr_p1;
    logic [DATA_W-1:0] dm_wdata_p1;
    logic              dm_gnt_p1;
    logic              dm_rvalid_p1;
    logic [DATA_W-1:0] dm_rdata_p1;
    logic              err_p1;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int checks;
    int errors;

    mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_LAT   (MEM_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_p1   (if_req_p1),
        .if_addr_p1  (if_addr_p1),
        .if_gnt_p1   (if_gnt_p1),
        .if_rvalid_p1(if_rvalid_p1),
        .if_rdata_p1 (if_rdata_p1),
        .dm_req_p1   (dm_req_p1),
        .dm_wr_p1    (dm_wr_p1),
        .dm_addr_p1  (dm_addr_p1),
        .dm_wdata_p1 (dm_wdata_p1),
        .dm_gnt_p1   (dm_gnt_p1),
        .dm_rvalid_p1(dm_rvalid_p1),
        .dm_rdata_p1 (dm_rdata_p1),
        .err_p1      (err_p1),
        .mem_en      (mem_en),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read data = addr ^ 0x480F, returned exactly MEM_LAT cycles
    // after mem_en; junk (0xA5A5) otherwise. Never reset, so an in-flight
    // response still appears on mem_rdata across a reset.
    logic              pipe_en   [MEM_LAT];
    logic [ADDR_W-1:0] pipe_addr [MEM_LAT];

    initial begin
        for (int i = 0; i < MEM_LAT; i++) begin
            pipe_en[i]   = 1'b0;
            pipe_addr[i] = '0;
        end
    end

    always @(posedge clk) begin
        pipe_en[0]   <= mem_en;
        pipe_addr[0] <= mem_addr;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_en[i]   <= pipe_en[i-1];
            pipe_addr[i] <= pipe_addr[i-1];
        end
    end

    assign mem_rdata = pipe_en[MEM_LAT-1] ? (pipe_addr[MEM_LAT-1] ^ 16'h480F) : 16'hA5A5;

    logic [70:0] all_out;
    assign all_out = {if_gnt_p1, if_rvalid_p1, if_rdata_p1, dm_gnt_p1, dm_rvalid_p1,
                      dm_rdata_p1, err_p1, mem_en, mem_wr, mem_addr, mem_wdata};

    task automatic test_reset();
        rst        = 1'b1;
        if_req_p1  = 1'b1;
        if_addr_p1 = 16'h0000;
        dm_req_p1  = 1'b1;
        dm_wr_p1   = 1'b0;
        dm_addr_p1 = 16'h0000;
        dm_wdata_p1 = 16'h0000;
        #1 rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (all_out !== 71'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        @(negedge clk);
        if_req_p1 = 1'b0;
        dm_req_p1 = 1'b0;
        rst       = 1'b1;
        #1;
        checks++;
        if (all_out !== 71'd0) begin
            errors++;
            $display("FAIL idle_outputs: got %h want 0", all_out);
        end
    endtask

    task automatic test_single_fetch();
        @(negedge clk);
        if_req_p1  = 1'b1;
        if_addr_p1 = 16'h0010;
        #1;
        checks++;
        if ({if_gnt_p1, dm_gnt_p1, mem_en, mem_wr, mem_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 16'h0010}) begin
            errors++;
            $display("FAIL fetch_grant: gnt=%b dm_gnt=%b en=%b wr=%b addr=%h want 1 0 1 0 0010",
                     if_gnt_p1, dm_gnt_p1, mem_en, mem_wr, mem_addr);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) if_req_p1 = 1'b0;
            #1;
            checks++;
            if ({if_rvalid_p1, if_gnt_p1, mem_en} !== 3'b000) begin
                errors++;
                $display("FAIL fetch_wait%0d: rvalid=%b gnt=%b en=%b want 000", k, if_rvalid_p1, if_gnt_p1, mem_en);
            end
        end
        @(negedge clk); #1;
        checks++;
        if ({if_rvalid_p1, if_rdata_p1, dm_rvalid_p1, err_p1} !== {1'b1, 16'h481F, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL fetch_resp: rvalid=%b rdata=%h dm_rvalid=%b err=%b want 1 481f 0 0",
                     if_rvalid_p1, if_rdata_p1, dm_rvalid_p1, err_p1);
        end
        @(negedge clk); #1;
        checks++;
        if ({if_rvalid_p1, if_rdata_p1} !== 17'd0) begin
            errors++;
            $display("FAIL fetch_after: rvalid=%b rdata=%h want 0 0000", if_rvalid_p1, if_rdata_p1);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        if_req_p1  = 1'b1;
        if_addr_p1 = 16'h0020;
        dm_req_p1  = 1'b1;
        dm_wr_p1   = 1'b0;
        dm_addr_p1 = 16'h0200;
        #1;
        checks++;
        if ({dm_gnt_p1, if_gnt_p1, mem_addr} !== {1'b1, 1'b0, 16'h0200}) begin
            errors++;
            $display("FAIL simul_first: dm_gnt=%b if_gnt=%b addr=%h want 1 0 0200", dm_gnt_p1, if_gnt_p1, mem_addr);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) dm_req_p1 = 1'b0;
            #1;
            checks++;
            if ({if_gnt_p1, dm_rvalid_p1} !== 2'b00) begin
                errors++;
                $display("FAIL simul_wait%0d: if_gnt=%b dm_rvalid=%b want 00", k, if_gnt_p1, dm_rvalid_p1);
            end
        end
        @(negedge clk); #1;
        checks++;
        if ({dm_rvalid_p1, dm_rdata_p1, if_gnt_p1, mem_en, mem_addr} !== {1'b1, 16'h4A0F, 1'b1, 1'b1, 16'h0020}) begin
            errors++;
            $display("FAIL simul_overlap: dm_rvalid=%b dm_rdata=%h if_gnt=%b en=%b addr=%h want 1 4a0f 1 1 0020",
                     dm_rvalid_p1, dm_rdata_p1, if_gnt_p1, mem_en, mem_addr);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) if_req_p1 = 1'b0;
        end
        @(negedge clk); #1;
        checks++;
        if ({if_rvalid_p1, if_rdata_p1, dm_rvalid_p1} !== {1'b1, 16'h482F, 1'b0}) begin
            errors++;
            $display("FAIL simul_fetch_resp: rvalid=%b rdata=%h dm_rvalid=%b want 1 482f 0",
                     if_rvalid_p1, if_rdata_p1, dm_rvalid_p1);
        end
    endtask

    task automatic test_starvation();
        logic [4:0] exp_if;
        exp_if = 5'b01000;  // bit g set: fetch wins grant slot g
        @(negedge clk);
        if_req_p1  = 1'b1;
        if_addr_p1 = 16'h0050;
        dm_req_p1  = 1'b1;
        dm_wr_p1   = 1'b0;
        dm_addr_p1 = 16'h0200;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 4; c++) begin
                if (g != 0 || c != 0) @(negedge clk);
                if (g == 4 && c == 1) begin
                    if_req_p1 = 1'b0;
                    dm_req_p1 = 1'b0;
                end
                #1;
                checks++;
                if (c == 0) begin
                    if ({if_gnt_p1, dm_gnt_p1} !== {exp_if[g], ~exp_if[g]}) begin
                        errors++;
                        $display("FAIL starve_slot%0d: if_gnt=%b dm_gnt=%b want %b %b",
                                 g, if_gnt_p1, dm_gnt_p1, exp_if[g], ~exp_if[g]);
                    end
                end else begin
                    if ({if_gnt_p1, dm_gnt_p1} !== 2'b00) begin
                        errors++;
                        $display("FAIL starve_gap%0d_%0d: if_gnt=%b dm_gnt=%b want 00", g, c, if_gnt_p1, dm_gnt_p1);
                    end
                end
            end
        end
        @(negedge clk); #1;
        checks++;
        if ({dm_rvalid_p1, dm_rdata_p1} !== {1'b1, 16'h4A0F}) begin
            errors++;
            $display("FAIL starve_last_resp: dm_rvalid=%b rdata=%h want 1 4a0f", dm_rvalid_p1, dm_rdata_p1);
        end
    endtask

    task automatic test_store();
        @(negedge clk);
        dm_req_p1   = 1'b1;
        dm_wr_p1    = 1'b1;
        dm_addr_p1  = 16'h0100;
        dm_wdata_p1 = 16'hBEEF;
        #1;
        checks++;
        if ({dm_gnt_p1, mem_en, mem_wr, mem_addr, mem_wdata} !== {1'b1, 1'b1, 1'b1, 16'h0100, 16'hBEEF}) begin
            errors++;
            $display("FAIL store_grant: gnt=%b en=%b wr=%b addr=%h wdata=%h want 1 1 1 0100 beef",
                     dm_gnt_p1, mem_en, mem_wr, mem_addr, mem_wdata);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                dm_req_p1 = 1'b0;
                dm_wr_p1  = 1'b0;
            end
        end
        @(negedge clk); #1;
        checks++;
        if ({dm_rvalid_p1, dm_rdata_p1, err_p1, if_rvalid_p1} !== {1'b1, 16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL store_resp: rvalid=%b rdata=%h err=%b if_rvalid=%b want 1 0000 0 0",
                     dm_rvalid_p1, dm_rdata_p1, err_p1, if_rvalid_p1);
        end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        dm_req_p1  = 1'b1;
        dm_wr_p1   = 1'b0;
        dm_addr_p1 = 16'h0101;
        if_req_p1  = 1'b1;
        if_addr_p1 = 16'h0030;
        #1;
        checks++;
        if ({dm_gnt_p1, if_gnt_p1, mem_en, mem_addr} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL misal_grant: dm_gnt=%b if_gnt=%b en=%b addr=%h want 1 0 0 0000",
                     dm_gnt_p1, if_gnt_p1, mem_en, mem_addr);
        end
        @(negedge clk);
        dm_req_p1 = 1'b0;
        #1;
        checks++;
        if ({dm_rvalid_p1, err_p1, dm_rdata_p1, if_gnt_p1, mem_en, mem_addr} !==
            {1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 16'h0030}) begin
            errors++;
            $display("FAIL misal_resp: rvalid=%b err=%b rdata=%h if_gnt=%b en=%b addr=%h want 1 1 0000 1 1 0030",
                     dm_rvalid_p1, err_p1, dm_rdata_p1, if_gnt_p1, mem_en, mem_addr);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) if_req_p1 = 1'b0;
        end
        @(negedge clk); #1;
        checks++;
        if ({if_rvalid_p1, if_rdata_p1, err_p1} !== {1'b1, 16'h483F, 1'b0}) begin
            errors++;
            $display("FAIL misal_fetch_resp: rvalid=%b rdata=%h err=%b want 1 483f 0", if_rvalid_p1, if_rdata_p1, err_p1);
        end
        // Misaligned fetch: error response on the fetch port one cycle later.
        @(negedge clk);
        if_req_p1  = 1'b1;
        if_addr_p1 = 16'h0011;
        #1;
        checks++;
        if ({if_gnt_p1, mem_en} !== 2'b10) begin
            errors++;
            $display("FAIL misal_fetch_grant: gnt=%b en=%b want 1 0", if_gnt_p1, mem_en);
        end
        @(negedge clk);
        if_req_p1 = 1'b0;
        #1;
        checks++;
        if ({if_rvalid_p1, err_p1, if_rdata_p1, dm_rvalid_p1} !== {1'b1, 1'b1, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL misal_fetch_resp: rvalid=%b err=%b rdata=%h dm_rvalid=%b want 1 1 0000 0",
                     if_rvalid_p1, err_p1, if_rdata_p1, dm_rvalid_p1);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        if_req_p1  = 1'b1;
        if_addr_p1 = 16'h0040;
        #1;
        checks++;
        if ({if_gnt_p1, mem_en, mem_addr} !== {1'b1, 1'b1, 16'h0040}) begin
            errors++;
            $display("FAIL rmid_grant: gnt=%b en=%b addr=%h want 1 1 0040", if_gnt_p1, mem_en, mem_addr);
        end
        @(negedge clk);
        if_req_p1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (all_out !== 71'd0) begin
            errors++;
            $display("FAIL rmid_immediate: got %h want 0", all_out);
        end
        @(negedge clk);
        if_req_p1 = 1'b1;
        #1;
        checks++;
        if (all_out !== 71'd0) begin
            errors++;
            $display("FAIL rmid_held_req: got %h want 0", all_out);
        end
        @(negedge clk); #1;
        checks++;
        if ({if_rvalid_p1, all_out} !== 72'd0) begin
            errors++;
            $display("FAIL rmid_no_rvalid: rvalid=%b outs=%h want 0", if_rvalid_p1, all_out);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({if_gnt_p1, mem_en, mem_addr} !== {1'b1, 1'b1, 16'h0040}) begin
            errors++;
            $display("FAIL rmid_release_grant: gnt=%b en=%b addr=%h want 1 1 0040", if_gnt_p1, mem_en, mem_addr);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) if_req_p1 = 1'b0;
        end
        @(negedge clk); #1;
        checks++;
        if ({if_rvalid_p1, if_rdata_p1} !== {1'b1, 16'h484F}) begin
            errors++;
            $display("FAIL rmid_resp: rvalid=%b rdata=%h want 1 484f", if_rvalid_p1, if_rdata_p1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_store();
        test_misaligned();
        test_reset_mid();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
